mips_bus_memory: RTL and testbench

- Avalon-MM-style memory slave that sits directly downstream of the CPU bus master and services its read/write/waitrequest/byteenable transfers.
- Provides one word-organised RAM window with a configurable wait-state count, so the CPU's stall and waitrequest handling is exercised.
- Used as the program/data memory in CPU testbenches and in system top-levels.

---
 rtl/mips_bus_memory.sv | 121 ++++++++++++
 tb/tb_mips_bus_memory.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_memory.sv
// Avalon-MM style word RAM slave with a configurable number of wait states.
// Out-of-window, unaligned and read+write requests complete normally but set a sticky bus_error.
module mips_bus_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;
  logic [31:0] mem [DEPTH];

  logic          req, in_idle, go_done, err, in_range, do_write;
  logic [31:0]   acc_addr, acc_wdata, rd_word;
  logic [3:0]    acc_be;
  logic          acc_rd, acc_wr;
  logic [29:0]   off_w;
  logic [AW-1:0] idx;

  // Elaboration-time clear; the RAM itself has no reset so contents survive reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign req     = read | write;
  assign in_idle = (state == IDLE);

  always_comb begin
    waitrequest = 1'b0;
    if (!reset) waitrequest = 1'b1;
    else begin
      case (state)
        IDLE:    waitrequest = req;
        WAIT:    waitrequest = 1'b1;
        default: waitrequest = 1'b0;
      endcase
    end
  end

  // With zero wait states the access happens on the same edge that samples the request.
  assign acc_addr  = in_idle ? address    : addr_q;
  assign acc_wdata = in_idle ? writedata  : wdata_q;
  assign acc_be    = in_idle ? byteenable : be_q;
  assign acc_rd    = in_idle ? read       : rd_q;
  assign acc_wr    = in_idle ? write      : wr_q;

  assign go_done = reset && ((in_idle && req && (WAIT_CYCLES == 0)) ||
                             ((state == WAIT) && req && (cnt == 4'd0)));

  assign off_w    = acc_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = ({2'b00, off_w} < 32'(DEPTH));
  assign err      = !in_range || (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
  assign idx      = off_w[AW-1:0];
  assign rd_word  = mem[idx];
  assign do_write = go_done && acc_wr && !acc_rd && !err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      readdata  <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= writedata;
            be_q    <= byteenable;
            rd_q    <= read;
            wr_q    <= write;
            if (WAIT_CYCLES == 0) state <= DONE;
            else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else if (cnt == 4'd0) state <= DONE;
          else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (go_done) begin
        if (err) bus_error <= 1'b1;
        if (acc_rd) readdata <= err ? 32'd0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench for mips_bus_memory: a 2-wait-state instance and a 0-wait-state instance,
// checked against a behavioural memory model through a scoreboard queue.
module tb_mips_bus_memory;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [31:0] address = '0, writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        rq_read = 1'b0, rq_write = 1'b0;
  int          sel = 0;

  logic        read2, write2, waitrequest2, bus_error2;
  logic        read0, write0, waitrequest0, bus_error0;
  logic [31:0] readdata2, readdata0;
  logic        wr_obs, err_obs;
  logic [31:0] rd_obs;

  assign read2  = (sel == 0) && rq_read;
  assign write2 = (sel == 0) && rq_write;
  assign read0  = (sel == 1) && rq_read;
  assign write0 = (sel == 1) && rq_write;
  assign wr_obs  = (sel == 1) ? waitrequest0 : waitrequest2;
  assign rd_obs  = (sel == 1) ? readdata0    : readdata2;
  assign err_obs = (sel == 1) ? bus_error0   : bus_error2;

  mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .address(address), .read(read2), .write(write2),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest2), .readdata(readdata2), .bus_error(bus_error2)
  );

  mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(read0), .write(write0),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest0), .readdata(readdata0), .bus_error(bus_error0)
  );

  int          checks = 0, errors = 0;
  exp_t        sb[$];
  logic [31:0] mm[int];
  logic [31:0] m_rd[2] = '{32'd0, 32'd0};
  logic        m_err[2] = '{1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input logic r, input logic w, input logic [31:0] a,
                                  input logic [3:0] be, input logic [31:0] d);
    exp_t        e;
    logic [31:0] off, cur;
    bit          bad;
    int          key;
    off = a - BASE;
    bad = (off >= 32'(4 * DEPTH)) || (a[1:0] != 2'b00) || (r && w);
    key = sel * DEPTH + int'(off >> 2);
    if (bad) begin
      m_err[sel] = 1'b1;
      if (r) m_rd[sel] = 32'd0;
    end else begin
      cur = mm.exists(key) ? mm[key] : 32'd0;
      if (r) m_rd[sel] = cur;
      else if (w) begin
        for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
        mm[key] = cur;
      end
    end
    e.data = m_rd[sel];
    e.err  = m_err[sel];
    e.lat  = (sel == 1) ? 1 : 3;
    sb.push_back(e);
  endfunction

  task automatic xfer(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    int   cyc;
    predict(r, w, a, be, d);
    @(posedge clk); #1;
    rq_read = r; rq_write = w; address = a; byteenable = be; writedata = d;
    @(negedge clk);
    chk({tag, "_wait_at_T"}, {31'd0, wr_obs}, 32'd1);
    cyc = 0;
    while (wr_obs && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rq_read = 1'b0; rq_write = 1'b0;
    e = sb.pop_front();
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_readdata"}, rd_obs, e.data);
    chk({tag, "_bus_error"}, {31'd0, err_obs}, {31'd0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", {31'd0, waitrequest2}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_wait", {31'd0, waitrequest2}, 32'd0);
    chk("post_reset_rdata", readdata2, 32'd0);
    chk("post_reset_err", {31'd0, bus_error2}, 32'd0);

    xfer("wr_beef", 1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
    xfer("rd_beef", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    xfer("wr_lane2", 1'b0, 1'b1, BASE + 32'h10, 4'b0100, 32'h00AA0000);
    xfer("rd_lane2", 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0);
    xfer("wr_be0", 1'b0, 1'b1, BASE + 32'h10, 4'b0000, 32'hFFFFFFFF);
    xfer("rd_be0", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    xfer("wr_w5", 1'b0, 1'b1, BASE + 32'h14, 4'hF, 32'h11223344);
    xfer("rd_w5", 1'b1, 1'b0, BASE + 32'h14, 4'h0, 32'h0);
    xfer("rd_oor_low", 1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0);
    xfer("rd_after_err", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    xfer("wr_unaligned", 1'b0, 1'b1, BASE + 32'h2, 4'hF, 32'hCAFEF00D);
    xfer("wr_oor_high", 1'b0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h5A5A5A5A);
    xfer("wr_oor_below", 1'b0, 1'b1, BASE - 32'h4, 4'hF, 32'hA5A5A5A5);
    xfer("rd_w0_clean", 1'b1, 1'b0, BASE, 4'h0, 32'h0);
    xfer("wr_top", 1'b0, 1'b1, BASE + 32'(4 * DEPTH - 4), 4'hF, 32'h0BADF00D);
    xfer("rd_top", 1'b1, 1'b0, BASE + 32'(4 * DEPTH - 4), 4'h0, 32'h0);
    xfer("rw_both", 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h0);
    xfer("rd_after_rw", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);

    // Abort: request dropped in the last WAIT cycle must not complete
    @(posedge clk); #1 rq_read = 1'b1; address = BASE + 32'h14;
    @(posedge clk); #1;
    @(posedge clk); #1 rq_read = 1'b0;
    @(negedge clk);
    chk("abort_wait_held", {31'd0, wr_obs}, 32'd1);
    @(negedge clk);
    chk("abort_idle", {31'd0, wr_obs}, 32'd0);
    chk("abort_rdata", rd_obs, m_rd[0]);
    @(negedge clk);
    chk("abort_rdata_hold", rd_obs, m_rd[0]);
    xfer("wr_after_abort", 1'b0, 1'b1, BASE + 32'h18, 4'hF, 32'h12345678);
    xfer("rd_after_abort", 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);

    // Reset lands on the edge that would otherwise commit the write
    @(posedge clk); #1 rq_write = 1'b1; address = BASE + 32'h18;
    writedata = 32'h99999999; byteenable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait", {31'd0, wr_obs}, 32'd1);
    @(posedge clk); #1 reset = 1'b1; rq_write = 1'b0;
    m_rd[0] = 32'd0; m_rd[1] = 32'd0; m_err[0] = 1'b0; m_err[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdata", rd_obs, 32'd0);
    chk("rst_mid_err", {31'd0, err_obs}, 32'd0);
    chk("rst_mid_idle", {31'd0, wr_obs}, 32'd0);
    xfer("rd_kept_word", 1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);
    xfer("rd_kept_lane", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);

    sel = 1;
    xfer("z_wr0", 1'b0, 1'b1, BASE + 32'h0, 4'hF, 32'hA0A0A0A0);
    xfer("z_wr1", 1'b0, 1'b1, BASE + 32'h4, 4'hF, 32'hB1B1B1B1);
    xfer("z_wr2", 1'b0, 1'b1, BASE + 32'h8, 4'b0011, 32'hC2C2C2C2);
    xfer("z_rd0", 1'b1, 1'b0, BASE + 32'h0, 4'h0, 32'h0);
    xfer("z_rd1", 1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0);
    xfer("z_rd2", 1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0);
    xfer("z_rd_unaligned", 1'b1, 1'b0, BASE + 32'h5, 4'h0, 32'h0);
    xfer("z_rd_after_err", 1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
